// File: rtl/irq_pkg.sv
// Shared constants for the IO bank 0x07 interrupt controller: register offsets,
// the "no interrupt" vector code and CTRL bit positions.
package irq_pkg;

  localparam logic [7:0] IRQ_IO_BANK = 8'h07;

  localparam logic [2:0] IRQ_REG_STATUS = 3'd0;
  localparam logic [2:0] IRQ_REG_RAW    = 3'd1;
  localparam logic [2:0] IRQ_REG_EN     = 3'd2;
  localparam logic [2:0] IRQ_REG_MODE   = 3'd3;
  localparam logic [2:0] IRQ_REG_VECTOR = 3'd4;
  localparam logic [2:0] IRQ_REG_CTRL   = 3'd5;
  localparam logic [2:0] IRQ_REG_NMISEL = 3'd6;

  localparam logic [7:0] VEC_NONE = 8'h80;

  localparam int unsigned CTRL_GIE_BIT   = 0;
  localparam int unsigned CTRL_SWSET_BIT = 1;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchroniser chain with a previous-value flop and rising-edge detect.
module irq_sync
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= src_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~s_prev_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: sync, latch, mask and prioritise sources.
// Optional NMI routing (NMI_SEL register, nmi_o port) under `IRQ_CONTROLLER_NMI_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               R_W_n,
  input  logic [7:0]         reg_addr_i,
  input  logic [7:0]         reg_addr_r_i,
  input  logic [7:0]         data_i,
  input  logic               irq_cs,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [7:0]         data_o,
`ifdef IRQ_CONTROLLER_NMI_EN
  output logic               nmi_o,
`endif
  output logic               irq_o
);

  logic [NUM_SRC-1:0] pend_q, en_q, mode_q, nmisel_q;
  logic               gie_q;
  logic [NUM_SRC-1:0] s, rise, clr, swset, pend_nxt, eligible;
  logic               wr;
  logic [7:0]         vec, rd_val;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^{reg_addr_i[7:3], reg_addr_r_i[7:3]};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .src_i  (src_i[g]),
      .s_o    (s[g]),
      .rise_o (rise[g])
    );
  end

`ifdef IRQ_CONTROLLER_NMI_EN
  assign eligible = pend_q & en_q & ~nmisel_q;
`else
  assign nmisel_q = '0;
  assign eligible = pend_q & en_q;
`endif

  always_comb begin
    wr    = irq_cs & ~R_W_n;
    clr   = '0;
    swset = '0;
    if (wr && reg_addr_i[2:0] == IRQ_REG_STATUS) clr = data_i[NUM_SRC-1:0];
    if (wr && reg_addr_i[2:0] == IRQ_REG_CTRL && data_i[CTRL_SWSET_BIT]) swset[NUM_SRC-1] = 1'b1;
    // Edge mode: a new edge or software set outranks a coincident clear.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pend_nxt[i] = mode_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i] | swset[i])
                              : (s[i] | swset[i]);
    end
  end

  always_comb begin
    vec = VEC_NONE;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eligible[i-1]) vec = 8'(i - 1);
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (reg_addr_r_i[2:0])
      IRQ_REG_STATUS: rd_val = 8'(eligible);
      IRQ_REG_RAW:    rd_val = 8'(pend_q);
      IRQ_REG_EN:     rd_val = 8'(en_q);
      IRQ_REG_MODE:   rd_val = 8'(mode_q);
      IRQ_REG_VECTOR: rd_val = vec;
      IRQ_REG_CTRL:   rd_val = {7'b0, gie_q};
`ifdef IRQ_CONTROLLER_NMI_EN
      IRQ_REG_NMISEL: rd_val = 8'(nmisel_q);
`endif
      default:        rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      gie_q  <= 1'b0;
      data_o <= 8'h00;
      irq_o  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      if (wr && reg_addr_i[2:0] == IRQ_REG_EN)   en_q   <= data_i[NUM_SRC-1:0];
      if (wr && reg_addr_i[2:0] == IRQ_REG_MODE) mode_q <= data_i[NUM_SRC-1:0];
      if (wr && reg_addr_i[2:0] == IRQ_REG_CTRL) gie_q  <= data_i[CTRL_GIE_BIT];
      data_o <= irq_cs ? rd_val : 8'h00;
      irq_o  <= gie_q & |eligible;
    end
  end

`ifdef IRQ_CONTROLLER_NMI_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nmisel_q <= '0;
      nmi_o    <= 1'b0;
    end else begin
      if (wr && reg_addr_i[2:0] == IRQ_REG_NMISEL) nmisel_q <= data_i[NUM_SRC-1:0];
      nmi_o <= |(pend_q & nmisel_q);
    end
  end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: register reads are queued with their
// expected values and compared when data_o returns one cycle later.
module tb_irq_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       R_W_n = 1'b1;
  logic [7:0] reg_addr_i = '0;
  logic [7:0] reg_addr_r_i = '0;
  logic [7:0] data_i = '0;
  logic       irq_cs = 1'b0;
  logic [7:0] src_i = '0;
  logic [7:0] data_o;
  logic       irq_o;
`ifdef IRQ_CONTROLLER_NMI_EN
  logic       nmi_o;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  exp_q[$];
  logic [2:0]  addr_q[$];

  irq_controller #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .R_W_n        (R_W_n),
    .reg_addr_i   (reg_addr_i),
    .reg_addr_r_i (reg_addr_r_i),
    .data_i       (data_i),
    .irq_cs       (irq_cs),
    .src_i        (src_i),
    .data_o       (data_o),
`ifdef IRQ_CONTROLLER_NMI_EN
    .nmi_o        (nmi_o),
`endif
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    irq_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = {5'b0, a}; data_i = d;
    tick();
    irq_cs = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    irq_cs = 1'b1; R_W_n = 1'b1; reg_addr_r_i = {5'b0, a};
    tick();
    v = data_o;
    irq_cs = 1'b0;
  endtask

  task automatic expect_reg(input logic [2:0] a, input logic [7:0] e);
    addr_q.push_back(a);
    exp_q.push_back(e);
  endtask

  // Drains the scoreboard: reads each queued address and compares the result.
  task automatic drain(input string tag);
    logic [7:0] got, e;
    logic [2:0] a;
    while (exp_q.size() > 0) begin
      a = addr_q.pop_front();
      e = exp_q.pop_front();
      rd(a, got);
      n_total++;
      if (got !== e) $display("FAIL %s reg%0d: got %h expected %h", tag, a, got, e);
      else n_pass++;
    end
  endtask

  task automatic do_reset();
    src_i = '0; irq_cs = 1'b0; R_W_n = 1'b1;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic e);
    n_total++;
    if (irq_o !== e) $display("FAIL %s irq_o: got %b expected %b", tag, irq_o, e);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    check_irq("reset", 1'b0);
    n_total++;
    if (data_o !== 8'h00) $display("FAIL reset data_o: got %h expected 00", data_o);
    else n_pass++;
    expect_reg(0, 8'h00); expect_reg(1, 8'h00); expect_reg(2, 8'h00);
    expect_reg(3, 8'h00); expect_reg(4, 8'h80); expect_reg(5, 8'h00);
    expect_reg(6, 8'h00); expect_reg(7, 8'h00);
    drain("reset");
    tick();
    n_total++;
    if (data_o !== 8'h00) $display("FAIL no_cs data_o: got %h expected 00", data_o);
    else n_pass++;
`ifndef IRQ_CONTROLLER_NMI_EN
    wr(6, 8'hFF);
    expect_reg(6, 8'h00);
    drain("addr6_ignored");
`endif
  endtask

  task automatic test_edge();
    do_reset();
    wr(3, 8'hFF); wr(2, 8'h02); wr(5, 8'h01);
    src_i[1] = 1'b1;
    tick(); tick(); tick();
    check_irq("edge_latency_e3", 1'b0);
    src_i[1] = 1'b0;
    tick();
    check_irq("edge_latency_e4", 1'b1);
    expect_reg(0, 8'h02); expect_reg(4, 8'h01); expect_reg(1, 8'h02);
    drain("edge_pending");
    wr(0, 8'h02);
    tick();
    check_irq("edge_w1c", 1'b0);
    expect_reg(4, 8'h80); expect_reg(0, 8'h00);
    drain("edge_cleared");
  endtask

  task automatic test_level();
    do_reset();
    wr(3, 8'h00); wr(2, 8'h01); wr(5, 8'h01);
    src_i[0] = 1'b1;
    tick(); tick(); tick(); tick();
    check_irq("level_assert", 1'b1);
    wr(0, 8'h01);
    expect_reg(1, 8'h01);
    drain("level_w1c_noop");
    check_irq("level_hold", 1'b1);
    src_i[0] = 1'b0;
    tick(); tick(); tick();
    check_irq("level_drop_e3", 1'b1);
    tick();
    check_irq("level_drop_e4", 1'b0);
    expect_reg(1, 8'h00);
    drain("level_released");
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(3, 8'hFF); wr(2, 8'h28); wr(5, 8'h01);
    src_i[3] = 1'b1; src_i[5] = 1'b1;
    tick(); tick(); tick(); tick();
    src_i = '0;
    expect_reg(4, 8'h03); expect_reg(0, 8'h28);
    drain("simul");
    tick(); tick(); tick();
    src_i[3] = 1'b1;
    tick(); tick();
    wr(0, 8'h08);
    expect_reg(1, 8'h28);
    drain("edge_vs_clear");
    wr(0, 8'h20);
    expect_reg(1, 8'h08); expect_reg(4, 8'h03);
    drain("clear_bit5");
    src_i = '0;
  endtask

  task automatic test_gie_swset();
    do_reset();
    wr(3, 8'hFF); wr(2, 8'h84); wr(5, 8'h00);
    src_i[2] = 1'b1;
    tick(); tick(); tick();
    src_i[2] = 1'b0;
    tick(); tick();
    check_irq("gie_off", 1'b0);
    expect_reg(0, 8'h04);
    drain("gie_off_status");
    wr(5, 8'h03);
    tick();
    check_irq("gie_on", 1'b1);
    expect_reg(1, 8'h84); expect_reg(5, 8'h01); expect_reg(4, 8'h02);
    drain("swset");
  endtask

`ifdef IRQ_CONTROLLER_NMI_EN
  task automatic test_nmi();
    do_reset();
    wr(3, 8'hFF); wr(2, 8'h04); wr(5, 8'h01); wr(6, 8'h04);
    src_i[2] = 1'b1;
    tick(); tick(); tick();
    src_i[2] = 1'b0;
    tick(); tick();
    n_total++;
    if (nmi_o !== 1'b1) $display("FAIL nmi nmi_o: got %b expected 1", nmi_o);
    else n_pass++;
    check_irq("nmi_irq_masked", 1'b0);
    expect_reg(4, 8'h80); expect_reg(6, 8'h04);
    drain("nmi");
  endtask
`endif

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_back_to_back();
    test_gie_swset();
`ifdef IRQ_CONTROLLER_NMI_EN
    test_nmi();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
